wb_initiator: RTL

Wishbone classic single-cycle initiator (bus master) that turns a simple valid/ready command stream into Wishbone read/write cycles and returns a response word. It is the driving end of the Wishbone slave port exposed by our user project wrapper. It is used for on-chip bring-up, where commands arrive from logic-analyzer lines or a test controller, and as the synthesizable master in wrapper-level benches. Each transaction is protected by a bus timeout, and the block keeps transaction and error counters.

---
 rtl/wb_initiator.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/wb_initiator.sv
// Wishbone classic single-cycle initiator.
// Accepts one command at a time on a valid/ready stream and runs it as a
// Wishbone read or write cycle. Each cycle is bounded by a timeout.
// The result is returned on a valid/ready response stream.
// Completed-response and timed-out-response counters are maintained.
module wb_initiator #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_adr,
    input  logic [31:0]      cmd_dat,
    input  logic [3:0]       cmd_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_dat,
    output logic             rsp_err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i,
    output logic [CNT_W-1:0] txn_count,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    // Cycle index at which an unacknowledged bus cycle is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic [7:0]         tmo_q, tmo_d;
    logic [CNT_W-1:0]   txn_q, txn_d;
    logic [7:0]         err_q, err_d;

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        tmo_d       = tmo_q;
        txn_d       = txn_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    cyc_d   = 1'b1;
                    tmo_d   = 8'd0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ack is checked first so a collision with the timeout is
                // treated as a normal completion.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = we_q ? 32'd0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = 32'd0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_d       = txn_q + 1'b1;
                    if (rsp_err_q && (err_q != 8'hFF)) begin
                        err_d = err_q + 8'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'd0;
            adr_q       <= 32'd0;
            dat_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'd0;
            rsp_err_q   <= 1'b0;
            tmo_q       <= 8'd0;
            txn_q       <= '0;
            err_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            tmo_q       <= tmo_d;
            txn_q       <= txn_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign txn_count = txn_q;
    assign err_count = err_q;

endmodule
